// File: rtl/mac_mv_seq_pkg.sv
// Shared types and widths for the matrix-vector MAC sequencer.
package mac_mv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MAC   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int OP_W  = 8;
    localparam int ACC_W = 19;
    localparam int N_MAX = 8;

endpackage

// File: rtl/mac_mv_seq_mac.sv
// 8x8 unsigned multiply-accumulate unit with synchronous clear.
module mac_mv_seq_mac
    import mac_mv_seq_pkg::*;
(
    input  logic [OP_W-1:0]  inA,
    input  logic [OP_W-1:0]  inB,
    input  logic             macc_clear,
    input  logic             clk,
    output logic [ACC_W-1:0] out
);

    logic [2*OP_W-1:0] prod;

    assign prod = inA * inB;

    always_ff @(posedge clk) begin
        if (macc_clear) begin
            out <= '0;
        end else begin
            out <= out + {{(ACC_W-2*OP_W){1'b0}}, prod};
        end
    end

endmodule

// File: rtl/mac_mv_seq.sv
// Sequencer computing y = A*x one row per clear/accumulate pass of the MAC.
//
// state | meaning
// IDLE  | waiting for start, MAC held cleared
// CLEAR | zero accumulator, present first operand addresses of the row
// MAC   | accumulate one product per cycle for N cycles, prefetching next
// WRITE | store row sum to result memory
// DONE  | one-cycle completion pulse
module mac_mv_seq
    import mac_mv_seq_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 8,
    parameter int AW = (M * N > 1) ? $clog2(M * N) : 1,
    parameter int XW = (N > 1) ? $clog2(N) : 1,
    parameter int RW = (M > 1) ? $clog2(M) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [AW-1:0]    a_addr,
    input  logic [OP_W-1:0]  a_data,
    output logic [XW-1:0]    x_addr,
    input  logic [OP_W-1:0]  x_data,
    output logic             res_we,
    output logic [RW-1:0]    res_addr,
    output logic [ACC_W-1:0] res_data
);

    localparam logic [XW-1:0] LAST_K   = XW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(N);

    state_t          state;
    logic [RW-1:0]   row;
    logic [XW-1:0]   k;
    logic [XW-1:0]   f;
    logic [AW-1:0]   row_base;

    logic             mac_clear;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic [ACC_W-1:0] mac_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            k        <= '0;
            f        <= '0;
            row_base <= '0;
            a_addr   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_we   <= 1'b0;
            res_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        row      <= '0;
                        row_base <= '0;
                        a_addr   <= '0;
                        f        <= '0;
                        k        <= '0;
                    end
                end
                CLEAR: begin
                    state <= MAC;
                    if (f != LAST_K) begin
                        f      <= f + XW'(1);
                        a_addr <= a_addr + AW'(1);
                    end
                end
                MAC: begin
                    // fetch index runs one ahead of k and parks on the last column
                    if (f != LAST_K) begin
                        f      <= f + XW'(1);
                        a_addr <= a_addr + AW'(1);
                    end
                    if (k == LAST_K) begin
                        state    <= WRITE;
                        k        <= '0;
                        res_we   <= 1'b1;
                        res_addr <= row;
                    end else begin
                        k <= k + XW'(1);
                    end
                end
                WRITE: begin
                    res_we <= 1'b0;
                    if (row == LAST_ROW) begin
                        state <= DONE;
                        done  <= 1'b1;
                        row   <= '0;
                    end else begin
                        state    <= CLEAR;
                        row      <= row + RW'(1);
                        row_base <= row_base + ROW_STEP;
                        a_addr   <= row_base + ROW_STEP;
                        f        <= '0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    row_base <= '0;
                    a_addr   <= '0;
                    f        <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign x_addr = f;

    // Clear is held outside active rows so a fresh start always sees a zero accumulator.
    assign mac_clear = reset || (state == IDLE) || (state == CLEAR) || (state == DONE);
    assign mac_a     = (state == MAC) ? a_data : '0;
    assign mac_b     = (state == MAC) ? x_data : '0;
    assign res_data  = res_we ? mac_out : '0;

    mac_mv_seq_mac u_mac (
        .inA        (mac_a),
        .inB        (mac_b),
        .macc_clear (mac_clear),
        .clk        (clk),
        .out        (mac_out)
    );

endmodule

// File: tb/tb_mac_mv_seq.sv
// Scoreboard bench for mac_mv_seq across several M/N configurations.
module tb_mac_mv_seq;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   sel = 0;

    always #5 clk = ~clk;

    logic [7:0] amem [0:31];
    logic [7:0] xmem [0:7];

    // instance 1: M=2 N=3
    logic st1, busy1, done1, we1;
    logic [2:0] aa1; logic [1:0] xa1; logic [0:0] ra1;
    logic [7:0] ad1, xd1; logic [18:0] rd1;
    // instance 2: M=1 N=8
    logic st2, busy2, done2, we2;
    logic [2:0] aa2; logic [2:0] xa2; logic [0:0] ra2;
    logic [7:0] ad2, xd2; logic [18:0] rd2;
    // instance 3: M=1 N=1
    logic st3, busy3, done3, we3;
    logic [0:0] aa3; logic [0:0] xa3; logic [0:0] ra3;
    logic [7:0] ad3, xd3; logic [18:0] rd3;
    // instance 4: M=4 N=4
    logic st4, busy4, done4, we4;
    logic [3:0] aa4; logic [1:0] xa4; logic [1:0] ra4;
    logic [7:0] ad4, xd4; logic [18:0] rd4;

    mac_mv_seq #(.N(3), .M(2)) u1 (
        .clk(clk), .reset(reset), .start(st1), .busy(busy1), .done(done1),
        .a_addr(aa1), .a_data(ad1), .x_addr(xa1), .x_data(xd1),
        .res_we(we1), .res_addr(ra1), .res_data(rd1));
    mac_mv_seq #(.N(8), .M(1)) u2 (
        .clk(clk), .reset(reset), .start(st2), .busy(busy2), .done(done2),
        .a_addr(aa2), .a_data(ad2), .x_addr(xa2), .x_data(xd2),
        .res_we(we2), .res_addr(ra2), .res_data(rd2));
    mac_mv_seq #(.N(1), .M(1)) u3 (
        .clk(clk), .reset(reset), .start(st3), .busy(busy3), .done(done3),
        .a_addr(aa3), .a_data(ad3), .x_addr(xa3), .x_data(xd3),
        .res_we(we3), .res_addr(ra3), .res_data(rd3));
    mac_mv_seq #(.N(4), .M(4)) u4 (
        .clk(clk), .reset(reset), .start(st4), .busy(busy4), .done(done4),
        .a_addr(aa4), .a_data(ad4), .x_addr(xa4), .x_data(xd4),
        .res_we(we4), .res_addr(ra4), .res_data(rd4));

    always @(posedge clk) begin
        ad1 <= amem[aa1]; xd1 <= xmem[xa1];
        ad2 <= amem[aa2]; xd2 <= xmem[xa2];
        ad3 <= amem[aa3]; xd3 <= xmem[xa3];
        ad4 <= amem[aa4]; xd4 <= xmem[xa4];
    end

    logic mon_we, mon_busy, mon_done;
    int   mon_res_addr, mon_data, mon_a, mon_x;

    always_comb begin
        mon_we = 1'b0; mon_busy = 1'b0; mon_done = 1'b0;
        mon_res_addr = 0; mon_data = 0; mon_a = 0; mon_x = 0;
        case (sel)
            1: begin mon_we = we1; mon_busy = busy1; mon_done = done1; mon_res_addr = int'(ra1);
                     mon_data = int'(rd1); mon_a = int'(aa1); mon_x = int'(xa1); end
            2: begin mon_we = we2; mon_busy = busy2; mon_done = done2; mon_res_addr = int'(ra2);
                     mon_data = int'(rd2); mon_a = int'(aa2); mon_x = int'(xa2); end
            3: begin mon_we = we3; mon_busy = busy3; mon_done = done3; mon_res_addr = int'(ra3);
                     mon_data = int'(rd3); mon_a = int'(aa3); mon_x = int'(xa3); end
            4: begin mon_we = we4; mon_busy = busy4; mon_done = done4; mon_res_addr = int'(ra4);
                     mon_data = int'(rd4); mon_a = int'(aa4); mon_x = int'(xa4); end
            default: ;
        endcase
    end

    task automatic set_start(input int w, input logic v);
        case (w)
            1: st1 = v;
            2: st2 = v;
            3: st3 = v;
            4: st4 = v;
            default: ;
        endcase
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) amem[i] = 8'd0;
        for (int i = 0; i < 8; i++) xmem[i] = 8'd0;
    endtask

    // Starts a product at edge 0 and checks every cycle until done+1 (or budget).
    task automatic run_product(input int w, input int m, input int n, input int restart_cyc,
                               input int reset_cyc, input int budget);
        sb_t q[$];
        sb_t e;
        int  exp_done, busy_end, y, r, j, ea, ex;
        bit  finished;
        exp_done = (reset_cyc > 0) ? -1 : m * (n + 2) + 1;
        busy_end = (reset_cyc > 0) ? reset_cyc : exp_done;
        finished = 1'b0;
        for (int rr = 0; rr < m; rr++) begin
            y = 0;
            for (int c = 0; c < n; c++) y += int'(amem[rr * n + c]) * int'(xmem[c]);
            e.addr = rr; e.data = y; e.cyc = (rr + 1) * (n + 2);
            if (reset_cyc <= 0 || e.cyc <= reset_cyc) q.push_back(e);
        end
        sel = w;
        set_start(w, 1'b1);
        @(posedge clk);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            if (mon_we) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_write: cycle %0d addr %0d data %0d, required no write", cyc, mon_res_addr, mon_data);
                end else begin
                    e = q.pop_front();
                    checks += 3;
                    if (mon_res_addr !== e.addr) begin
                        errors++;
                        $display("FAIL res_addr: got %0d required %0d (cycle %0d)", mon_res_addr, e.addr, cyc);
                    end
                    if (mon_data !== e.data) begin
                        errors++;
                        $display("FAIL res_data: got %0d required %0d (row %0d)", mon_data, e.data, e.addr);
                    end
                    if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL write_cycle: got %0d required %0d (row %0d)", cyc, e.cyc, e.addr);
                    end
                end
            end else begin
                checks++;
                if (mon_data !== 0) begin
                    errors++;
                    $display("FAIL res_data_idle: got %0d required 0 (cycle %0d)", mon_data, cyc);
                end
            end
            if (reset_cyc <= 0 || cyc <= reset_cyc) begin
                r = (cyc - 1) / (n + 2);
                j = (cyc - 1) % (n + 2);
                if (r < m && j <= n) begin
                    ex = (j < n - 1) ? j : n - 1;
                    ea = r * n + ex;
                    checks += 2;
                    if (mon_a !== ea) begin
                        errors++;
                        $display("FAIL a_addr: got %0d required %0d (row %0d step %0d)", mon_a, ea, r, j);
                    end
                    if (mon_x !== ex) begin
                        errors++;
                        $display("FAIL x_addr: got %0d required %0d (row %0d step %0d)", mon_x, ex, r, j);
                    end
                end
            end
            checks++;
            if (mon_busy !== (cyc <= busy_end)) begin
                errors++;
                $display("FAIL busy: got %0d required %0d (cycle %0d)", mon_busy, (cyc <= busy_end), cyc);
            end
            if (mon_done) begin
                checks++;
                if (cyc !== exp_done) begin
                    errors++;
                    $display("FAIL done_cycle: got %0d required %0d", cyc, exp_done);
                end
            end
            if (reset_cyc > 0 && cyc == reset_cyc + 1) begin
                checks++;
                if (mon_we !== 1'b0 || mon_done !== 1'b0 || mon_a !== 0 || mon_x !== 0 || mon_res_addr !== 0) begin
                    errors++;
                    $display("FAIL after_reset: we %0d done %0d a %0d x %0d ra %0d, required all 0",
                             mon_we, mon_done, mon_a, mon_x, mon_res_addr);
                end
            end
            if (exp_done > 0 && cyc == exp_done + 1) begin
                checks++;
                if (mon_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_pulse: got %0d required 0 after done", mon_done);
                end
                finished = 1'b1;
            end
            set_start(w, 1'b0);
            reset = 1'b0;
            if (cyc == restart_cyc) set_start(w, 1'b1);
            if (cyc == reset_cyc) reset = 1'b1;
            if (finished) break;
        end
        if (exp_done > 0) begin
            checks++;
            if (!finished) begin
                errors++;
                $display("FAIL timeout: done not seen within %0d cycles, required cycle %0d", budget, exp_done);
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding required 0", q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        st1 = 1'b0; st2 = 1'b0; st3 = 1'b0; st4 = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 1; w <= 4; w++) begin
            sel = w;
            #1;
            checks++;
            if (mon_busy !== 1'b0 || mon_done !== 1'b0 || mon_we !== 1'b0 || mon_data !== 0 ||
                mon_a !== 0 || mon_x !== 0 || mon_res_addr !== 0) begin
                errors++;
                $display("FAIL reset_state: inst %0d busy %0d done %0d we %0d data %0d a %0d x %0d ra %0d, required all 0",
                         w, mon_busy, mon_done, mon_we, mon_data, mon_a, mon_x, mon_res_addr);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small();
        clear_mem();
        for (int i = 0; i < 6; i++) amem[i] = 8'(i + 1);
        xmem[0] = 8'd1; xmem[1] = 8'd1; xmem[2] = 8'd2;
        run_product(1, 2, 3, 0, 0, 40);
    endtask

    task automatic test_overflow();
        clear_mem();
        for (int i = 0; i < 8; i++) begin amem[i] = 8'd255; xmem[i] = 8'd255; end
        run_product(2, 1, 8, 0, 0, 40);
    endtask

    task automatic test_single();
        clear_mem();
        amem[0] = 8'd7; xmem[0] = 8'd9;
        run_product(3, 1, 1, 0, 0, 20);
    endtask

    task automatic test_back_to_back();
        clear_mem();
        for (int i = 0; i < 6; i++) amem[i] = 8'(i + 1);
        xmem[0] = 8'd1; xmem[1] = 8'd1; xmem[2] = 8'd2;
        run_product(1, 2, 3, 3, 0, 40);
        run_product(1, 2, 3, 11, 0, 40);
        run_product(1, 2, 3, 0, 0, 40);
    endtask

    task automatic test_reset_mid_run();
        clear_mem();
        for (int i = 0; i < 16; i++) amem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) xmem[i] = 8'($urandom_range(0, 255));
        run_product(4, 4, 4, 0, 9, 30);
        run_product(4, 4, 4, 0, 0, 60);
    endtask

    task automatic test_address();
        clear_mem();
        for (int i = 0; i < 16; i++) amem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) xmem[i] = 8'($urandom_range(0, 255));
        run_product(4, 4, 4, 0, 0, 60);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_small();
        test_overflow();
        test_single();
        test_back_to_back();
        test_reset_mid_run();
        test_address();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
